// File: rtl/pe_port_arbiter.sv
// Round-robin arbiter feeding one LVT memory port register from several PEs.
// Every issued read is tagged so its returning data can be routed to the PE that asked.
module pe_port_arbiter #(
  parameter int unsigned index_width        = 8,
  parameter int unsigned data_width         = 64,
  parameter int unsigned processing_engines = 4,
  parameter int unsigned read_latency       = 2
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic [processing_engines-1:0]                i_req_valid,
  output logic [processing_engines-1:0]                o_req_ready,
  input  logic [processing_engines-1:0]                i_req_wen,
  input  logic [processing_engines*index_width-1:0]    i_req_addr,
  input  logic [processing_engines*data_width-1:0]     i_req_kandv,
  output logic                                         o_out_wen,
  output logic                                         o_out_ren,
  output logic [index_width-1:0]                       o_out_addr,
  output logic [data_width-1:0]                        o_out_write_kandv,
  output logic [data_width-1:0]                        o_out_read_kandv,
  input  logic [data_width-1:0]                        i_rd_data_in,
  output logic [processing_engines-1:0]                o_rsp_valid,
  output logic [data_width-1:0]                        o_rsp_data
);

  localparam int unsigned IdW = $clog2(processing_engines);

  logic [processing_engines-1:0] r_pending;
  logic [processing_engines-1:0] r_slot_wen;
  logic [index_width-1:0]        r_slot_addr  [processing_engines];
  logic [data_width-1:0]         r_slot_kandv [processing_engines];
  logic [IdW-1:0]                r_rr_ptr;

  logic                          r_out_wen;
  logic                          r_out_ren;
  logic [index_width-1:0]        r_out_addr;
  logic [data_width-1:0]         r_out_write_kandv;
  logic [data_width-1:0]         r_out_read_kandv;
  logic [IdW-1:0]                r_out_id;

  logic [read_latency-1:0]       r_tag_v;
  logic [IdW-1:0]                r_tag_id [read_latency];

  logic [processing_engines-1:0] w_accept;
  logic                          w_grant;
  logic [31:0]                   w_win_u;
  logic [IdW-1:0]                w_win;
  logic [IdW-1:0]                w_rr_next;

  assign o_req_ready = ~r_pending;
  // A pending slot is not ready, so capture and grant never hit the same slot on one edge.
  assign w_accept    = i_req_valid & ~r_pending;

  // Scan from rr_ptr downwards in priority so the closest pending slot is the last to win.
  always_comb begin
    logic [31:0] idx;
    w_grant = 1'b0;
    w_win_u = '0;
    idx     = '0;
    for (int unsigned k = processing_engines; k > 0; k--) begin
      idx = 32'(r_rr_ptr) + k - 32'd1;
      if (idx >= processing_engines) idx = idx - processing_engines;
      if (r_pending[idx[IdW-1:0]]) begin
        w_grant = 1'b1;
        w_win_u = idx;
      end
    end
  end

  assign w_win     = w_win_u[IdW-1:0];
  assign w_rr_next = (w_win_u == processing_engines - 1) ? '0 : IdW'(w_win_u + 32'd1);

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < int'(processing_engines); i++) begin
      if (w_accept[i]) begin
        r_slot_wen[i]   <= i_req_wen[i];
        r_slot_addr[i]  <= i_req_addr[i*index_width +: index_width];
        r_slot_kandv[i] <= i_req_kandv[i*data_width +: data_width];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending         <= '0;
      r_rr_ptr          <= '0;
      r_out_wen         <= 1'b0;
      r_out_ren         <= 1'b0;
      r_out_addr        <= '0;
      r_out_write_kandv <= '0;
      r_out_read_kandv  <= '0;
      r_out_id          <= '0;
    end else begin
      r_pending <= (r_pending | w_accept) &
                   ~(w_grant ? (processing_engines'(1) << w_win) : '0);
      if (w_grant) begin
        r_rr_ptr          <= w_rr_next;
        r_out_wen         <= r_slot_wen[w_win];
        r_out_ren         <= ~r_slot_wen[w_win];
        r_out_addr        <= r_slot_addr[w_win];
        r_out_write_kandv <= r_slot_wen[w_win] ? r_slot_kandv[w_win] : '0;
        r_out_read_kandv  <= r_slot_wen[w_win] ? '0 : r_slot_kandv[w_win];
        r_out_id          <= w_win;
      end else begin
        r_out_wen <= 1'b0;
        r_out_ren <= 1'b0;
      end
    end
  end

  // Stage 0 holds the read issued last cycle; the last stage lines up with returning data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_v <= '0;
      for (int k = 0; k < int'(read_latency); k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_v[0]  <= r_out_ren;
      r_tag_id[0] <= r_out_id;
      for (int k = 1; k < int'(read_latency); k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (r_tag_v[read_latency-1]) o_rsp_valid[r_tag_id[read_latency-1]] = 1'b1;
  end

  assign o_rsp_data        = i_rd_data_in;
  assign o_out_wen         = r_out_wen;
  assign o_out_ren         = r_out_ren;
  assign o_out_addr        = r_out_addr;
  assign o_out_write_kandv = r_out_write_kandv;
  assign o_out_read_kandv  = r_out_read_kandv;

endmodule

// File: tb/tb_pe_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_pe_port_arbiter;

  localparam int PE = 4;
  localparam int IW = 8;
  localparam int DW = 64;
  localparam int RL = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PE-1:0]    req_valid = '0;
  logic [PE-1:0]    req_ready;
  logic [PE-1:0]    req_wen = '0;
  logic [PE*IW-1:0] req_addr = '0;
  logic [PE*DW-1:0] req_kandv = '0;
  logic             out_wen, out_ren;
  logic [IW-1:0]    out_addr;
  logic [DW-1:0]    out_wk, out_rk;
  logic [DW-1:0]    rd_data = '0;
  logic [PE-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;

  int checks = 0;
  int errors = 0;

  pe_port_arbiter #(
    .index_width(IW), .data_width(DW), .processing_engines(PE), .read_latency(RL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_kandv(req_kandv),
    .o_out_wen(out_wen), .o_out_ren(out_ren), .o_out_addr(out_addr),
    .o_out_write_kandv(out_wk), .o_out_read_kandv(out_rk),
    .i_rd_data_in(rd_data), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Reference model: per-PE slots, a round-robin pointer and a queue of due responses.
  typedef struct { int due; int id; } rsp_t;
  rsp_t          rsp_q[$];
  logic [PE-1:0] m_pend, m_swen;
  logic [IW-1:0] m_saddr[PE];
  logic [DW-1:0] m_skv[PE];
  int            m_rr, m_cyc;
  logic          m_owen, m_oren;
  logic [IW-1:0] m_oaddr;
  logic [DW-1:0] m_owk, m_ork;

  task automatic m_reset();
    m_pend = '0; m_rr = 0;
    m_owen = 0; m_oren = 0; m_oaddr = '0; m_owk = '0; m_ork = '0;
    rsp_q.delete();
  endtask

  task automatic model_edge();
    int win;
    logic [PE-1:0] pend_old;
    pend_old = m_pend;
    win = -1;
    for (int k = 0; k < PE; k++) begin
      if (win < 0 && pend_old[(m_rr + k) % PE]) win = (m_rr + k) % PE;
    end
    if (win >= 0) begin
      m_pend[win] = 1'b0;
      m_rr    = (win + 1) % PE;
      m_owen  = m_swen[win];
      m_oren  = !m_swen[win];
      m_oaddr = m_saddr[win];
      m_owk   = m_swen[win] ? m_skv[win] : '0;
      m_ork   = m_swen[win] ? '0 : m_skv[win];
      if (!m_swen[win]) rsp_q.push_back('{due: m_cyc + 1 + RL, id: win});
    end else begin
      m_owen = 0; m_oren = 0;
    end
    for (int i = 0; i < PE; i++) begin
      if (req_valid[i] && !pend_old[i]) begin
        m_pend[i]  = 1'b1;
        m_swen[i]  = req_wen[i];
        m_saddr[i] = req_addr[i*IW +: IW];
        m_skv[i]   = req_kandv[i*DW +: DW];
      end
    end
  endtask

  function automatic logic [PE-1:0] exp_rsp();
    logic [PE-1:0] r;
    r = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == m_cyc) r[rsp_q[0].id] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    if (!rst_n) m_reset(); else model_edge();
    m_cyc++;
    @(posedge clk);
    #1;
    while (rsp_q.size() > 0 && rsp_q[0].due < m_cyc) void'(rsp_q.pop_front());
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int pe, input logic wen, input logic [IW-1:0] a,
                         input logic [DW-1:0] kv);
    req_valid[pe] = 1'b1;
    req_wen[pe] = wen;
    req_addr[pe*IW +: IW] = a;
    req_kandv[pe*DW +: DW] = kv;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({out_wen, out_ren, out_addr, out_wk, out_rk} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {out_wen, out_ren, out_addr});
    end
    checks++;
    if (req_ready !== 4'b1111) begin
      errors++; $display("FAIL reset_ready got %b required 1111", req_ready);
    end
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp got %b required 0000", rsp_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(1, 1'b1, 8'h05, 64'hAA);
    tick();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b1101) begin
      errors++; $display("FAIL single_ready got %b required 1101", req_ready);
    end
    tick();
    checks++;
    if ({out_wen, out_ren, out_addr, out_wk, out_rk} !== {1'b1, 1'b0, 8'h05, 64'hAA, 64'h0})
    begin
      errors++;
      $display("FAIL single_issue got wen=%b ren=%b addr=%h wk=%h rk=%h required 1 0 05 aa 0",
               out_wen, out_ren, out_addr, out_wk, out_rk);
    end
    tick();
    checks++;
    if (out_wen !== 1'b0 || out_ren !== 1'b0 || out_addr !== 8'h05) begin
      errors++; $display("FAIL single_idle got wen=%b ren=%b addr=%h required 0 0 05",
                         out_wen, out_ren, out_addr);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < PE; i++) set_req(i, 1'b1, 8'(8'h20 + i), 64'(i));
    tick();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL all4_ready got %b required 0000", req_ready);
    end
    for (int k = 0; k < PE; k++) begin
      tick();
      checks++;
      if (out_wen !== 1'b1 || out_addr !== 8'(8'h20 + k)) begin
        errors++; $display("FAIL all4_order step %0d got wen=%b addr=%h required 1 %h",
                           k, out_wen, out_addr, 8'(8'h20 + k));
      end
      checks++;
      if (req_ready[k] !== 1'b1) begin
        errors++; $display("FAIL all4_ready_back pe %0d got %b required 1", k, req_ready[k]);
      end
    end
  endtask

  task automatic test_alternate();
    int prev, n0, n2;
    prev = -1; n0 = 0; n2 = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      req_valid = '0;
      if (!m_pend[0]) set_req(0, 1'b1, 8'd0, 64'(c));
      if (!m_pend[2]) set_req(2, 1'b1, 8'd2, 64'(c));
      tick();
      if (out_wen) begin
        checks++;
        if (int'(out_addr) == prev || (out_addr !== 8'd0 && out_addr !== 8'd2)) begin
          errors++; $display("FAIL alternate cycle %0d got pe %0d previous %0d", c,
                             out_addr, prev);
        end
        prev = int'(out_addr);
        if (out_addr == 8'd0) n0++; else n2++;
      end
    end
    req_valid = '0;
    checks++;
    if (n0 < 8 || n2 < 8) begin
      errors++; $display("FAIL alternate_starve got n0=%0d n2=%0d required >=8 each", n0, n2);
    end
    tick(); tick();
  endtask

  task automatic test_read_response();
    do_reset();
    req_wen = '0;
    set_req(2, 1'b0, 8'h10, 64'hBEEF);
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({out_wen, out_ren, out_addr, out_wk, out_rk} !== {1'b0, 1'b1, 8'h10, 64'h0, 64'hBEEF})
    begin
      errors++; $display("FAIL read_issue got wen=%b ren=%b addr=%h rk=%h required 0 1 10 beef",
                         out_wen, out_ren, out_addr, out_rk);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL read_early got %b required 0000", rsp_valid);
    end
    tick();
    rd_data = 64'h1234;
    #1;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 64'h1234) begin
      errors++; $display("FAIL read_rsp got %b %h required 0100 1234", rsp_valid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL read_late got %b required 0000", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [PE-1:0] want[4];
    want[0] = 4'b0000; want[1] = 4'b1000; want[2] = 4'b0001; want[3] = 4'b0000;
    do_reset();
    req_wen = '0;
    set_req(3, 1'b0, 8'h33, 64'h3);
    tick();
    req_valid = '0;
    set_req(0, 1'b0, 8'h44, 64'h4);
    tick();
    req_valid = '0;
    checks++;
    if (out_ren !== 1'b1 || out_addr !== 8'h33) begin
      errors++; $display("FAIL b2b_issue3 got ren=%b addr=%h required 1 33", out_ren, out_addr);
    end
    tick();
    checks++;
    if (out_ren !== 1'b1 || out_addr !== 8'h44) begin
      errors++; $display("FAIL b2b_issue0 got ren=%b addr=%h required 1 44", out_ren, out_addr);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (rsp_valid !== want[k]) begin
        errors++; $display("FAIL b2b_rsp step %0d got %b required %b", k, rsp_valid, want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_wen = '0;
    set_req(1, 1'b0, 8'h77, 64'h77);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({out_wen, out_ren, out_addr, out_wk, out_rk, rsp_valid} !== '0 ||
        req_ready !== 4'b1111) begin
      errors++; $display("FAIL midreset got wen=%b ren=%b addr=%h rsp=%b ready=%b",
                         out_wen, out_ren, out_addr, rsp_valid, req_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < RL + 2; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0000 || req_ready !== 4'b1111) begin
        errors++; $display("FAIL midreset_after step %0d got rsp=%b ready=%b", k, rsp_valid,
                           req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [PE-1:0] er;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom);
      req_wen   = 4'($urandom);
      for (int i = 0; i < PE; i++) begin
        req_addr[i*IW +: IW]  = 8'($urandom);
        req_kandv[i*DW +: DW] = {$urandom, $urandom};
      end
      rd_data = {$urandom, $urandom};
      if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
      tick();
      er = exp_rsp();
      checks++;
      if ({out_wen, out_ren, out_addr, out_wk, out_rk} !== {m_owen, m_oren, m_oaddr, m_owk, m_ork})
      begin
        errors++; $display("FAIL rand_out cycle %0d got %b%b %h %h %h required %b%b %h %h %h",
                           c, out_wen, out_ren, out_addr, out_wk, out_rk,
                           m_owen, m_oren, m_oaddr, m_owk, m_ork);
      end
      checks++;
      if (req_ready !== ~m_pend) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b required %b", c, req_ready, ~m_pend);
      end
      checks++;
      if (rsp_valid !== er || rsp_data !== rd_data) begin
        errors++; $display("FAIL rand_rsp cycle %0d got %b %h required %b %h", c, rsp_valid,
                           rsp_data, er, rd_data);
      end
      rst_n = 1'b1;
    end
  endtask

  initial begin
    m_cyc = 0;
    m_swen = '0;
    m_reset();
    test_reset();
    test_single_write();
    test_all_four();
    test_alternate();
    test_read_response();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
